// File: rtl/bird_kinematics_if.sv
// Control and sprite-state bundle between the game controller and the bird physics block.
interface bird_kinematics_if #(
    parameter int CW = 10,
    parameter int VW = 8
);
    logic                 Start;
    logic                 Stop;
    logic                 Ack;
    logic                 BtnPress;
    logic                 Tick;
    logic [CW-1:0]        Bird_X_L;
    logic [CW-1:0]        Bird_X_R;
    logic [CW-1:0]        Bird_Y_T;
    logic [CW-1:0]        Bird_Y_B;
    logic signed [VW-1:0] Velocity;
    logic                 HitFloor;
    logic                 q_Initial;
    logic                 q_Flight;
    logic                 q_Stop;

    modport master (
        output Start, Stop, Ack, BtnPress, Tick,
        input  Bird_X_L, Bird_X_R, Bird_Y_T, Bird_Y_B, Velocity, HitFloor,
               q_Initial, q_Flight, q_Stop
    );

    modport slave (
        input  Start, Stop, Ack, BtnPress, Tick,
        output Bird_X_L, Bird_X_R, Bird_Y_T, Bird_Y_B, Velocity, HitFloor,
               q_Initial, q_Flight, q_Stop
    );
endinterface

// File: rtl/bird_kinematics.sv
// Vertical bird physics: gravity, flap impulse, ceiling/floor clamping and
// an INIT/FLIGHT/STOP game-state machine, updated once per Tick strobe.
module bird_kinematics #(
    parameter int CW       = 10,
    parameter int VW       = 8,
    parameter int SCREEN_H = 480,
    parameter int BIRD_W   = 20,
    parameter int BIRD_H   = 20,
    parameter int X0       = 300,
    parameter int Y0       = 220,
    parameter int JUMP_V   = 8,
    parameter int GRAVITY  = 1,
    parameter int VMAX     = 12
) (
    input  logic               Clk,
    input  logic               reset,
    bird_kinematics_if.slave   bus
);
    localparam int NW = CW + 2;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        FLIGHT = 2'd1,
        STOP   = 2'd2
    } state_t;

    localparam logic signed [NW-1:0] FLOOR_S = NW'(SCREEN_H - BIRD_H);
    localparam logic signed [VW:0]   GRAV_S  = (VW+1)'(GRAVITY);
    localparam logic signed [VW:0]   VMAX_S  = (VW+1)'(VMAX);
    localparam logic signed [VW-1:0] VJUMP_S = VW'(-JUMP_V);

    state_t               state_q, state_d;
    logic [CW-1:0]        y_q, y_d;
    logic signed [VW-1:0] vel_q, vel_d;
    logic                 jmp_q, jmp_d;
    logic                 btn_q;
    logic                 hit_q, hit_d;

    logic                 btn_edge;
    logic                 jump;
    logic signed [NW-1:0] ny;
    logic signed [VW:0]   vel_sum;
    logic signed [VW-1:0] vel_grav;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q <= INIT;
            y_q     <= CW'(Y0);
            vel_q   <= '0;
            jmp_q   <= 1'b0;
            btn_q   <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            vel_q   <= vel_d;
            jmp_q   <= jmp_d;
            btn_q   <= bus.BtnPress;
            hit_q   <= hit_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        y_d      = y_q;
        vel_d    = vel_q;
        jmp_d    = jmp_q;
        hit_d    = 1'b0;
        btn_edge = bus.BtnPress & ~btn_q;
        jump     = jmp_q | btn_edge;
        // Next position uses the pre-update velocity, widened so both
        // overshoot above the ceiling and below the floor stay representable.
        ny       = $signed({2'b00, y_q}) + NW'(vel_q);
        vel_sum  = (VW+1)'(vel_q) + GRAV_S;
        vel_grav = (vel_sum > VMAX_S) ? VW'(VMAX_S) : vel_sum[VW-1:0];

        case (state_q)
            INIT: begin
                y_d   = CW'(Y0);
                vel_d = '0;
                jmp_d = 1'b0;
                if (bus.Start) state_d = FLIGHT;
            end
            FLIGHT: begin
                jmp_d = jump;
                if (bus.Tick) begin
                    jmp_d = 1'b0;
                    vel_d = jump ? VJUMP_S : vel_grav;
                    if (ny < 0) begin
                        y_d   = '0;
                        vel_d = jump ? VJUMP_S : '0;
                    end else if (ny > FLOOR_S) begin
                        // Floor contact ends the flight regardless of a pending flap.
                        y_d     = CW'(SCREEN_H - BIRD_H);
                        vel_d   = '0;
                        hit_d   = 1'b1;
                        state_d = STOP;
                    end else begin
                        y_d = ny[CW-1:0];
                    end
                end
                if (bus.Stop) state_d = STOP;
            end
            STOP: begin
                if (bus.Ack) state_d = INIT;
            end
            default: state_d = INIT;
        endcase
    end

    assign bus.Bird_X_L  = CW'(X0);
    assign bus.Bird_X_R  = CW'(X0 + BIRD_W);
    assign bus.Bird_Y_T  = y_q;
    assign bus.Bird_Y_B  = y_q + CW'(BIRD_H);
    assign bus.Velocity  = vel_q;
    assign bus.HitFloor  = hit_q;
    assign bus.q_Initial = (state_q == INIT);
    assign bus.q_Flight  = (state_q == FLIGHT);
    assign bus.q_Stop    = (state_q == STOP);
endmodule

// File: tb/tb_bird_kinematics.sv
// Directed bench for bird_kinematics with hand-computed trajectories.
module tb_bird_kinematics;
    logic Clk;
    logic reset;
    int   checks;
    int   errors;

    bird_kinematics_if #(.CW(10), .VW(8)) bus ();

    bird_kinematics dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Stimulus helpers: every call returns #1 after the edge that consumed the input.
    task automatic pulse_tick();
        @(posedge Clk); #1 bus.Tick = 1'b1;
        @(posedge Clk); #1 bus.Tick = 1'b0;
    endtask

    task automatic jump_tick();
        @(posedge Clk); #1 begin bus.Tick = 1'b1; bus.BtnPress = 1'b1; end
        @(posedge Clk); #1 begin bus.Tick = 1'b0; bus.BtnPress = 1'b0; end
    endtask

    task automatic press_btn();
        @(posedge Clk); #1 bus.BtnPress = 1'b1;
        @(posedge Clk); #1 bus.BtnPress = 1'b0;
    endtask

    task automatic do_start();
        @(posedge Clk); #1 bus.Start = 1'b1;
        @(posedge Clk); #1 bus.Start = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge Clk); #1 reset = 1'b1;
        @(posedge Clk); #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge Clk); #1 reset = 1'b1;
        #1;
        checks++;
        if ({bus.q_Initial, bus.q_Flight, bus.q_Stop} !== 3'b100) begin
            errors++; $display("FAIL reset_state got %b want 100", {bus.q_Initial, bus.q_Flight, bus.q_Stop});
        end
        checks++;
        if (bus.Bird_Y_T !== 10'd220 || bus.Bird_Y_B !== 10'd240) begin
            errors++; $display("FAIL reset_y got %0d/%0d want 220/240", bus.Bird_Y_T, bus.Bird_Y_B);
        end
        checks++;
        if (bus.Bird_X_L !== 10'd300 || bus.Bird_X_R !== 10'd320) begin
            errors++; $display("FAIL reset_x got %0d/%0d want 300/320", bus.Bird_X_L, bus.Bird_X_R);
        end
        checks++;
        if (bus.Velocity !== 8'sd0 || bus.HitFloor !== 1'b0) begin
            errors++; $display("FAIL reset_vel got %0d hit %b want 0/0", bus.Velocity, bus.HitFloor);
        end
        @(posedge Clk); #1 reset = 1'b0;
    endtask

    task automatic test_init_ignores_tick();
        pulse_tick();
        checks++;
        if (bus.Bird_Y_T !== 10'd220 || bus.Velocity !== 8'sd0 || bus.q_Initial !== 1'b1) begin
            errors++; $display("FAIL init_tick got y %0d v %0d init %b want 220 0 1", bus.Bird_Y_T, bus.Velocity, bus.q_Initial);
        end
    endtask

    task automatic test_fall();
        int exp_y[4] = '{220, 221, 223, 226};
        int exp_v[4] = '{1, 2, 3, 4};
        do_start();
        checks++;
        if (bus.q_Flight !== 1'b1) begin
            errors++; $display("FAIL start_flight got %b want 1", bus.q_Flight);
        end
        for (int i = 0; i < 4; i++) begin
            pulse_tick();
            checks++;
            if (bus.Bird_Y_T !== 10'(exp_y[i]) || bus.Velocity !== 8'(exp_v[i])) begin
                errors++; $display("FAIL fall_%0d got y %0d v %0d want y %0d v %0d", i, bus.Bird_Y_T, bus.Velocity, exp_y[i], exp_v[i]);
            end
            checks++;
            if (bus.Bird_Y_B !== 10'(exp_y[i] + 20)) begin
                errors++; $display("FAIL fall_yb_%0d got %0d want %0d", i, bus.Bird_Y_B, exp_y[i] + 20);
            end
        end
    endtask

    task automatic test_jump();
        do_reset();
        do_start();
        press_btn();
        pulse_tick();
        checks++;
        if (bus.Bird_Y_T !== 10'd220 || bus.Velocity !== -8'sd8) begin
            errors++; $display("FAIL jump_apply got y %0d v %0d want 220 -8", bus.Bird_Y_T, bus.Velocity);
        end
        pulse_tick();
        checks++;
        if (bus.Bird_Y_T !== 10'd212 || bus.Velocity !== -8'sd7) begin
            errors++; $display("FAIL jump_rise got y %0d v %0d want 212 -7", bus.Bird_Y_T, bus.Velocity);
        end
    endtask

    task automatic test_btn_held();
        do_reset();
        do_start();
        @(posedge Clk); #1 bus.BtnPress = 1'b1;
        for (int i = 0; i < 5; i++) pulse_tick();
        checks++;
        if (bus.Bird_Y_T !== 10'd194 || bus.Velocity !== -8'sd4) begin
            errors++; $display("FAIL btn_held got y %0d v %0d want 194 -4", bus.Bird_Y_T, bus.Velocity);
        end
        bus.BtnPress = 1'b0;
    endtask

    task automatic test_ceiling();
        do_reset();
        do_start();
        for (int i = 0; i < 28; i++) jump_tick();
        checks++;
        if (bus.Bird_Y_T !== 10'd4 || bus.Velocity !== -8'sd8) begin
            errors++; $display("FAIL ceil_setup got y %0d v %0d want 4 -8", bus.Bird_Y_T, bus.Velocity);
        end
        pulse_tick();
        checks++;
        if (bus.Bird_Y_T !== 10'd0 || bus.Velocity !== 8'sd0) begin
            errors++; $display("FAIL ceil_clamp got y %0d v %0d want 0 0", bus.Bird_Y_T, bus.Velocity);
        end
        jump_tick();
        jump_tick();
        checks++;
        if (bus.Bird_Y_T !== 10'd0 || bus.Velocity !== -8'sd8) begin
            errors++; $display("FAIL ceil_jump_wins got y %0d v %0d want 0 -8", bus.Bird_Y_T, bus.Velocity);
        end
    endtask

    task automatic test_floor();
        do_reset();
        do_start();
        for (int i = 0; i < 13; i++) pulse_tick();
        checks++;
        if (bus.Bird_Y_T !== 10'd298 || bus.Velocity !== 8'sd12) begin
            errors++; $display("FAIL vmax_sat got y %0d v %0d want 298 12", bus.Bird_Y_T, bus.Velocity);
        end
        for (int i = 0; i < 13; i++) pulse_tick();
        checks++;
        if (bus.Bird_Y_T !== 10'd454 || bus.Velocity !== 8'sd12 || bus.HitFloor !== 1'b0) begin
            errors++; $display("FAIL pre_floor got y %0d v %0d hit %b want 454 12 0", bus.Bird_Y_T, bus.Velocity, bus.HitFloor);
        end
        pulse_tick();
        checks++;
        if (bus.Bird_Y_T !== 10'd460 || bus.Bird_Y_B !== 10'd480 || bus.Velocity !== 8'sd0) begin
            errors++; $display("FAIL floor_clamp got y %0d/%0d v %0d want 460/480 0", bus.Bird_Y_T, bus.Bird_Y_B, bus.Velocity);
        end
        checks++;
        if (bus.HitFloor !== 1'b1 || bus.q_Stop !== 1'b1) begin
            errors++; $display("FAIL floor_hit got hit %b stop %b want 1 1", bus.HitFloor, bus.q_Stop);
        end
        @(posedge Clk); #1;
        checks++;
        if (bus.HitFloor !== 1'b0) begin
            errors++; $display("FAIL hit_pulse_width got %b want 0", bus.HitFloor);
        end
        jump_tick();
        pulse_tick();
        checks++;
        if (bus.Bird_Y_T !== 10'd460 || bus.Velocity !== 8'sd0 || bus.q_Stop !== 1'b1) begin
            errors++; $display("FAIL stop_frozen got y %0d v %0d stop %b want 460 0 1", bus.Bird_Y_T, bus.Velocity, bus.q_Stop);
        end
        @(posedge Clk); #1 bus.Ack = 1'b1;
        @(posedge Clk); #1 bus.Ack = 1'b0;
        @(posedge Clk); #1;
        checks++;
        if (bus.q_Initial !== 1'b1 || bus.Bird_Y_T !== 10'd220 || bus.Velocity !== 8'sd0) begin
            errors++; $display("FAIL ack_init got init %b y %0d v %0d want 1 220 0", bus.q_Initial, bus.Bird_Y_T, bus.Velocity);
        end
    endtask

    task automatic test_stop();
        do_start();
        pulse_tick();
        @(posedge Clk); #1 bus.Stop = 1'b1;
        @(posedge Clk); #1 bus.Stop = 1'b0;
        pulse_tick();
        checks++;
        if (bus.q_Stop !== 1'b1 || bus.Bird_Y_T !== 10'd220 || bus.Velocity !== 8'sd1) begin
            errors++; $display("FAIL stop_input got stop %b y %0d v %0d want 1 220 1", bus.q_Stop, bus.Bird_Y_T, bus.Velocity);
        end
    endtask

    task automatic test_reset_mid_flight();
        do_reset();
        do_start();
        pulse_tick();
        pulse_tick();
        press_btn();
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.q_Initial !== 1'b1 || bus.Bird_Y_T !== 10'd220 || bus.Velocity !== 8'sd0) begin
            errors++; $display("FAIL mid_reset got init %b y %0d v %0d want 1 220 0", bus.q_Initial, bus.Bird_Y_T, bus.Velocity);
        end
        @(posedge Clk); #1 reset = 1'b0;
        do_start();
        pulse_tick();
        checks++;
        if (bus.Bird_Y_T !== 10'd220 || bus.Velocity !== 8'sd1) begin
            errors++; $display("FAIL jump_abandoned got y %0d v %0d want 220 1", bus.Bird_Y_T, bus.Velocity);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b0;
        bus.Start    = 1'b0;
        bus.Stop     = 1'b0;
        bus.Ack      = 1'b0;
        bus.BtnPress = 1'b0;
        bus.Tick     = 1'b0;
        test_reset();
        test_init_ignores_tick();
        test_fall();
        test_jump();
        test_btn_held();
        test_ceiling();
        test_floor();
        test_stop();
        test_reset_mid_flight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
